// File: rtl/traffic_light_pkg.sv
// Shared types, light encodings and default phase durations for the
// intersection controller.
package traffic_light_pkg;

  typedef enum logic [2:0] {
    MAIN_GREEN  = 3'd0,
    MAIN_YELLOW = 3'd1,
    ALL_RED_1   = 3'd2,
    SIDE_GREEN  = 3'd3,
    SIDE_YELLOW = 3'd4,
    ALL_RED_2   = 3'd5,
    PED_WALK    = 3'd6
  } tl_state_t;

  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_GREEN  = 3'b001;

  localparam logic [7:0] MAIN_MIN_T_DEF = 8'd8;
  localparam logic [7:0] YELLOW_T_DEF   = 8'd3;
  localparam logic [7:0] ALL_RED_T_DEF  = 8'd1;
  localparam logic [7:0] SIDE_T_DEF     = 8'd6;
  localparam logic [7:0] PED_T_DEF     = 8'd5;

  typedef struct packed {
    logic [2:0] main_light;
    logic [2:0] side_light;
    logic       walk;
  } tl_lights_t;

  // Unlisted encodings fall back to all-red so no road ever sees a spurious go.
  function automatic tl_lights_t decode_lights(input tl_state_t s);
    tl_lights_t l;
    l = '{main_light: LIGHT_RED, side_light: LIGHT_RED, walk: 1'b0};
    case (s)
      MAIN_GREEN:  l.main_light = LIGHT_GREEN;
      MAIN_YELLOW: l.main_light = LIGHT_YELLOW;
      SIDE_GREEN:  l.side_light = LIGHT_GREEN;
      SIDE_YELLOW: l.side_light = LIGHT_YELLOW;
      PED_WALK:    l.walk       = 1'b1;
      default:     l.walk       = 1'b0;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/traffic_light_controller_phase_timer.sv
// 8-bit phase down-counter: loads a value, decrements to zero, then holds.
module phase_timer #(
  parameter logic [7:0] RESET_VALUE = 8'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_value,
  output logic       zero
);

  logic [7:0] count_r;

  // Counter register: load wins over decrement, and zero is sticky until reloaded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= RESET_VALUE;
    end else if (load) begin
      count_r <= load_value;
    end else if (count_r != 8'd0) begin
      count_r <= count_r - 8'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign zero = (count_r == 8'd0);

endmodule

// File: rtl/traffic_light_controller.sv
// Two-road intersection controller with pedestrian walk phase; Moore FSM
// sequenced by a single phase timer.
module traffic_light_controller
  import traffic_light_pkg::*;
#(
  parameter logic [7:0] MAIN_MIN_T = MAIN_MIN_T_DEF,
  parameter logic [7:0] YELLOW_T   = YELLOW_T_DEF,
  parameter logic [7:0] ALL_RED_T  = ALL_RED_T_DEF,
  parameter logic [7:0] SIDE_T     = SIDE_T_DEF,
  parameter logic [7:0] PED_T      = PED_T_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pedestrian_button,
  input  logic       traffic_sensor,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic       pedestrian_signal
);

  tl_state_t  state_r;
  tl_state_t  next_state_s;
  logic       ped_req_r;
  logic       timer_zero_s;
  logic       load_s;
  logic [7:0] load_value_s;
  tl_lights_t lights_r;

  // Timer reload value: the counter runs duration-1 down to 0, so a phase
  // lasts exactly its duration in cycles.
  function automatic logic [7:0] phase_reload(input tl_state_t s);
    logic [7:0] d;
    case (s)
      MAIN_GREEN:  d = MAIN_MIN_T;
      MAIN_YELLOW: d = YELLOW_T;
      SIDE_YELLOW: d = YELLOW_T;
      ALL_RED_1:   d = ALL_RED_T;
      ALL_RED_2:   d = ALL_RED_T;
      SIDE_GREEN:  d = SIDE_T;
      PED_WALK:    d = PED_T;
      default:     d = MAIN_MIN_T;
    endcase
    return d - 8'd1;
  endfunction

  phase_timer #(
    .RESET_VALUE(MAIN_MIN_T - 8'd1)
  ) u_phase_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (load_s),
    .load_value (load_value_s),
    .zero       (timer_zero_s)
  );

  // Next-state logic; once main green is left the sequence runs to completion.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      MAIN_GREEN: begin
        if (timer_zero_s && (ped_req_r || traffic_sensor)) begin
          next_state_s = MAIN_YELLOW;
        end else begin
          next_state_s = MAIN_GREEN;
        end
      end
      MAIN_YELLOW: begin
        if (timer_zero_s) begin
          next_state_s = ALL_RED_1;
        end else begin
          next_state_s = MAIN_YELLOW;
        end
      end
      ALL_RED_1: begin
        if (timer_zero_s && ped_req_r) begin
          next_state_s = PED_WALK;
        end else if (timer_zero_s) begin
          next_state_s = SIDE_GREEN;
        end else begin
          next_state_s = ALL_RED_1;
        end
      end
      SIDE_GREEN: begin
        if (timer_zero_s) begin
          next_state_s = SIDE_YELLOW;
        end else begin
          next_state_s = SIDE_GREEN;
        end
      end
      SIDE_YELLOW: begin
        if (timer_zero_s) begin
          next_state_s = ALL_RED_2;
        end else begin
          next_state_s = SIDE_YELLOW;
        end
      end
      ALL_RED_2, PED_WALK: begin
        if (timer_zero_s) begin
          next_state_s = MAIN_GREEN;
        end else begin
          next_state_s = state_r;
        end
      end
      default: next_state_s = MAIN_GREEN;
    endcase
  end

  assign load_s       = (next_state_s != state_r);
  assign load_value_s = phase_reload(next_state_s);

  // State register and output register, updated together from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= MAIN_GREEN;
      lights_r <= decode_lights(MAIN_GREEN);
    end else begin
      state_r  <= next_state_s;
      lights_r <= decode_lights(next_state_s);
    end
  end

  // Pedestrian request latch; presses during the walk itself are ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ped_req_r <= 1'b0;
    end else if (load_s && (next_state_s == PED_WALK)) begin
      ped_req_r <= 1'b0;
    end else if (pedestrian_button && (state_r != PED_WALK)) begin
      ped_req_r <= 1'b1;
    end else begin
      ped_req_r <= ped_req_r;
    end
  end

  assign main_light        = lights_r.main_light;
  assign side_light        = lights_r.side_light;
  assign pedestrian_signal = lights_r.walk;

endmodule

// File: tb/tb_traffic_light_controller.sv
// Directed-vector bench for traffic_light_controller with default durations.
module tb_traffic_light_controller;

  logic       clk;
  logic       reset;
  logic       pedestrian_button;
  logic       traffic_sensor;
  logic [2:0] main_light;
  logic [2:0] side_light;
  logic       pedestrian_signal;

  int vectors;
  int miscompares;

  // {main, side, walk}
  localparam logic [6:0] V_MG = 7'b001_100_0;
  localparam logic [6:0] V_MY = 7'b010_100_0;
  localparam logic [6:0] V_AR = 7'b100_100_0;
  localparam logic [6:0] V_SG = 7'b100_001_0;
  localparam logic [6:0] V_SY = 7'b100_010_0;
  localparam logic [6:0] V_PW = 7'b100_100_1;

  traffic_light_controller dut (
    .clk               (clk),
    .reset             (reset),
    .pedestrian_button (pedestrian_button),
    .traffic_sensor    (traffic_sensor),
    .main_light        (main_light),
    .side_light        (side_light),
    .pedestrian_signal (pedestrian_signal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b_%b_%b expected %b_%b_%b at %0t", tag,
               obs[6:4], obs[3:1], obs[0], exp[6:4], exp[3:1], exp[0], $time);
    end
  endtask

  function automatic logic [6:0] outs();
    return {main_light, side_light, pedestrian_signal};
  endfunction

  // Check the displayed phase for n consecutive cycles, sampling on negedges.
  task automatic expect_phase(input string tag, input logic [6:0] exp, input int n);
    for (int i = 0; i < n; i++) begin
      check_vec(tag, outs(), exp);
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    reset             = 1'b1;
    pedestrian_button = 1'b0;
    traffic_sensor    = 1'b0;
    #1;
    check_vec("reset_async", outs(), V_MG);
    repeat (2) @(negedge clk);
    check_vec("reset_held", outs(), V_MG);
    reset = 1'b0;
  endtask

  initial begin
    vectors           = 0;
    miscompares       = 0;
    reset             = 1'b1;
    pedestrian_button = 1'b0;
    traffic_sensor    = 1'b0;

    // Idle: main green rests indefinitely.
    do_reset();
    expect_phase("idle_mg", V_MG, 200);

    // Sensor held: full side-road cycle, then main green minimum again.
    do_reset();
    traffic_sensor = 1'b1;
    expect_phase("sens_mg", V_MG, 8);
    expect_phase("sens_my", V_MY, 3);
    expect_phase("sens_ar1", V_AR, 1);
    expect_phase("sens_sg", V_SG, 6);
    expect_phase("sens_sy", V_SY, 3);
    expect_phase("sens_ar2", V_AR, 1);
    expect_phase("sens_mg2", V_MG, 8);

    // Two-cycle button pulse at cycle 20, sensor low.
    do_reset();
    expect_phase("btn_mg", V_MG, 19);
    pedestrian_button = 1'b1;
    expect_phase("btn_mg_req", V_MG, 2);
    pedestrian_button = 1'b0;
    expect_phase("btn_my", V_MY, 3);
    expect_phase("btn_ar1", V_AR, 1);
    expect_phase("btn_walk", V_PW, 5);
    expect_phase("btn_mg_after", V_MG, 10);

    // Button and sensor together: walk first, side road on the next exit.
    do_reset();
    expect_phase("both_mg", V_MG, 19);
    pedestrian_button = 1'b1;
    traffic_sensor    = 1'b1;
    expect_phase("both_mg_req", V_MG, 1);
    pedestrian_button = 1'b0;
    expect_phase("both_my", V_MY, 3);
    expect_phase("both_ar1", V_AR, 1);
    expect_phase("both_walk", V_PW, 5);
    expect_phase("both_mg2", V_MG, 8);
    expect_phase("both_my2", V_MY, 3);
    expect_phase("both_ar1b", V_AR, 1);
    expect_phase("both_sg", V_SG, 6);

    // Button held only during the walk must not request another walk.
    do_reset();
    expect_phase("hold_mg", V_MG, 19);
    pedestrian_button = 1'b1;
    expect_phase("hold_mg_req", V_MG, 1);
    pedestrian_button = 1'b0;
    expect_phase("hold_mg_wait", V_MG, 1);
    expect_phase("hold_my", V_MY, 3);
    expect_phase("hold_ar1", V_AR, 1);
    pedestrian_button = 1'b1;
    expect_phase("hold_walk", V_PW, 5);
    pedestrian_button = 1'b0;
    expect_phase("hold_mg_rest", V_MG, 40);

    // Reset mid side-green with a pending walk discards the request.
    do_reset();
    traffic_sensor = 1'b1;
    expect_phase("mid_mg", V_MG, 8);
    expect_phase("mid_my", V_MY, 3);
    expect_phase("mid_ar1", V_AR, 1);
    expect_phase("mid_sg", V_SG, 2);
    pedestrian_button = 1'b1;
    expect_phase("mid_sg_req", V_SG, 1);
    pedestrian_button = 1'b0;
    check_vec("mid_sg_pre_rst", outs(), V_SG);
    @(posedge clk);
    #2;
    reset          = 1'b1;
    traffic_sensor = 1'b0;
    #1;
    check_vec("mid_rst_async", outs(), V_MG);
    @(negedge clk);
    reset = 1'b0;
    expect_phase("mid_no_walk", V_MG, 40);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
